// File: rtl/i2c_write_master_if.sv
// Bus-side signal bundle of the I2C/SCCB write master: request, payload,
// open-drain pad controls and completion status.
interface i2c_write_master_if #(
    parameter int MAX_BYTES = 3
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);

    logic                   start;
    logic [NB_W-1:0]        numBytes;
    logic [8*MAX_BYTES-1:0] dataToSend;
    logic                   sdaIn;
    logic                   sdaDriveLow;
    logic                   sclDriveLow;
    logic                   busy;
    logic                   done;
    logic                   deviceAck;

    modport master (
        input  start, numBytes, dataToSend, sdaIn,
        output sdaDriveLow, sclDriveLow, busy, done, deviceAck
    );

    modport slave (
        output start, numBytes, dataToSend, sdaIn,
        input  sdaDriveLow, sclDriveLow, busy, done, deviceAck
    );
endinterface

// File: rtl/i2c_write_master.sv
// I2C/SCCB write-transaction engine: START, 1..MAX_BYTES bytes MSB-first with
// an ACK slot each, then STOP; SCL is derived from clk in quarter-period phases.
module i2c_write_master #(
    parameter int CLK_DIV     = 4,
    parameter int MAX_BYTES   = 3,
    parameter bit IGNORE_NACK = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    i2c_write_master_if.master bus
);
    localparam int NB_W  = $clog2(MAX_BYTES + 1);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DW    = 8 * MAX_BYTES;

    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BIT, STOP_A, STOP_B, STOP_C, FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;
    logic [NB_W-1:0] byte_q, byte_d;
    logic [NB_W-1:0] nbytes_q, nbytes_d;
    logic [DW-1:0]   data_q, data_d;
    logic            sda_q, sda_d;
    logic            scl_q, scl_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_q, ack_d;

    logic            tick;
    logic [3:0]      bit_inc;
    logic [DW-1:0]   data_shift;
    logic [NB_W-1:0] nb_clamped;
    logic            last_byte;

    assign tick       = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign bit_inc    = bit_q + 4'd1;
    assign data_shift = data_q >> 8;
    assign nb_clamped = (bus.numBytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : bus.numBytes;
    assign last_byte  = (byte_q == nbytes_q - NB_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = (busy_q && !tick) ? cnt_q + CNT_W'(1) : '0;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        nbytes_d = nbytes_q;
        data_d   = data_q;
        sda_d    = sda_q;
        scl_d    = scl_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ack_d    = ack_q;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE, so done_q blocks a back-to-back accept.
                if (bus.start && !done_q) begin
                    data_d   = bus.dataToSend;
                    nbytes_d = nb_clamped;
                    ack_d    = 1'b1;
                    byte_d   = '0;
                    cnt_d    = '0;
                    if (nb_clamped == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = START_A;
                        busy_d  = 1'b1;
                        sda_d   = 1'b1;
                        scl_d   = 1'b0;
                    end
                end
            end
            START_A: if (tick) begin
                state_d = START_B;
                sda_d   = 1'b1;
                scl_d   = 1'b1;
            end
            START_B: if (tick) begin
                state_d = BIT;
                qtr_d   = 2'd0;
                bit_d   = 4'd0;
                scl_d   = 1'b1;
                sda_d   = ~data_q[7];
            end
            BIT: if (tick) begin
                case (qtr_q)
                    2'd0: begin
                        qtr_d = 2'd1;
                        scl_d = 1'b0;
                    end
                    2'd1: qtr_d = 2'd2;
                    2'd2: begin
                        qtr_d = 2'd3;
                        scl_d = 1'b1;
                        if (bit_q == 4'd8 && bus.sdaIn) ack_d = 1'b0;
                    end
                    default: begin
                        qtr_d = 2'd0;
                        scl_d = 1'b1;
                        if (bit_q == 4'd8) begin
                            // ack_q already reflects this byte's ACK sample from q2.
                            if (last_byte || (!IGNORE_NACK && !ack_q)) begin
                                state_d = STOP_A;
                                sda_d   = 1'b1;
                            end else begin
                                byte_d = byte_q + NB_W'(1);
                                bit_d  = 4'd0;
                                data_d = data_shift;
                                sda_d  = ~data_shift[7];
                            end
                        end else begin
                            bit_d = bit_inc;
                            sda_d = (bit_inc == 4'd8) ? 1'b0 : ~data_q[3'd7 - bit_inc[2:0]];
                        end
                    end
                endcase
            end
            STOP_A: if (tick) begin
                state_d = STOP_B;
                scl_d   = 1'b0;
                sda_d   = 1'b1;
            end
            STOP_B: if (tick) begin
                state_d = STOP_C;
                scl_d   = 1'b0;
                sda_d   = 1'b0;
            end
            STOP_C: if (tick) begin
                state_d = FINISH;
                scl_d   = 1'b0;
                sda_d   = 1'b0;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                sda_d   = 1'b0;
                scl_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            byte_q   <= '0;
            nbytes_q <= '0;
            sda_q    <= 1'b0;
            scl_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            nbytes_q <= nbytes_d;
            sda_q    <= sda_d;
            scl_q    <= scl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
        end
        data_q <= data_d;
    end

    assign bus.sdaDriveLow = sda_q;
    assign bus.sclDriveLow = scl_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.deviceAck   = ack_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench: two masters (SCCB mode and abort-on-NACK) share one stimulus;
// SCL rises are decoded into bytes and START/STOP conditions are counted.
module tb_i2c_write_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  numBytes;
    logic [23:0] dataToSend;
    logic        sdaIn;

    int total = 0;
    int fails = 0;

    i2c_write_master_if #(.MAX_BYTES(3)) ifa();
    i2c_write_master_if #(.MAX_BYTES(3)) ifb();

    assign ifa.start = start;  assign ifa.numBytes = numBytes;
    assign ifa.dataToSend = dataToSend;  assign ifa.sdaIn = sdaIn;
    assign ifb.start = start;  assign ifb.numBytes = numBytes;
    assign ifb.dataToSend = dataToSend;  assign ifb.sdaIn = sdaIn;

    i2c_write_master #(.CLK_DIV(4), .MAX_BYTES(3), .IGNORE_NACK(1'b1)) ua (
        .clk(clk), .reset(reset), .bus(ifa.master));
    i2c_write_master #(.CLK_DIV(4), .MAX_BYTES(3), .IGNORE_NACK(1'b0)) ub (
        .clk(clk), .reset(reset), .bus(ifb.master));

    always #5 clk = ~clk;

    logic [1:0] o_sda, o_scl, o_busy, o_done, o_ack;
    assign o_sda  = {ifb.sdaDriveLow, ifa.sdaDriveLow};
    assign o_scl  = {ifb.sclDriveLow, ifa.sclDriveLow};
    assign o_busy = {ifb.busy, ifa.busy};
    assign o_done = {ifb.done, ifa.done};
    assign o_ack  = {ifb.deviceAck, ifa.deviceAck};

    int          lat[2], rises[2], starts[2], stops[2], dones[2];
    logic        ack_at_done[2], busy_at_done[2], busy_seen[2], pscl[2], psda[2];
    logic [39:0] bitv[2];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, input int k);
        if (pscl[d] && !o_scl[d]) begin
            rises[d]++;
            bitv[d] = {bitv[d][38:0], ~o_sda[d]};
        end
        if (!pscl[d] && !o_scl[d] && !psda[d] && o_sda[d]) starts[d]++;
        if (!pscl[d] && !o_scl[d] && psda[d] && !o_sda[d]) stops[d]++;
        if (o_busy[d]) busy_seen[d] = 1'b1;
        if (o_done[d]) begin
            dones[d]++;
            if (lat[d] < 0) begin
                lat[d] = k;
                ack_at_done[d]  = o_ack[d];
                busy_at_done[d] = o_busy[d];
            end
        end
        pscl[d] = o_scl[d];
        psda[d] = o_sda[d];
    endtask

    // glitch_k > 0 pulses a second start request after the k-th edge.
    task automatic run_txn(input int n, input logic [23:0] data, input logic sda,
                           input int glitch_k);
        @(negedge clk);
        start = 1'b1;  numBytes = 2'(n);  dataToSend = data;  sdaIn = sda;
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1;  rises[d] = 0;  starts[d] = 0;  stops[d] = 0;  dones[d] = 0;
            bitv[d] = '0;  busy_seen[d] = 1'b0;  ack_at_done[d] = 1'bx;  busy_at_done[d] = 1'bx;
            pscl[d] = o_scl[d];  psda[d] = o_sda[d];
        end
        @(posedge clk);
        #1;
        start = 1'b0;  numBytes = 2'd3;  dataToSend = ~data;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            sample(0, k);
            sample(1, k);
            if (k == glitch_k) begin
                start = 1'b1;  numBytes = 2'd1;  dataToSend = 24'hFFFFFF;
            end else if (k == glitch_k + 1) begin
                start = 1'b0;
            end
            if (lat[0] >= 0 && lat[1] >= 0) break;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("idle_after_done_a", 32'(o_busy[0]), 0);
        chk("idle_after_done_b", 32'(o_busy[1]), 0);
    endtask

    task automatic check_txn(input int d, input string nm, input int exp_lat,
                             input int exp_ack, input int n_sent, input int n_req,
                             input logic [23:0] data);
        int   exp_rises;
        logic [7:0] b;
        exp_rises = (n_sent > 0) ? 9 * n_sent + 1 : 0;
        chk({nm, "_latency"}, lat[d], exp_lat);
        chk({nm, "_ack"}, 32'(ack_at_done[d]), exp_ack);
        chk({nm, "_ack_held"}, 32'(o_ack[d]), exp_ack);
        chk({nm, "_busy_at_done"}, 32'(busy_at_done[d]), 0);
        chk({nm, "_busy_seen"}, 32'(busy_seen[d]), (n_req > 0) ? 1 : 0);
        chk({nm, "_done_pulses"}, dones[d], 1);
        chk({nm, "_scl_rises"}, rises[d], exp_rises);
        chk({nm, "_starts"}, starts[d], (n_req > 0) ? 1 : 0);
        chk({nm, "_stops"}, stops[d], (n_req > 0) ? 1 : 0);
        if (rises[d] == exp_rises) begin
            for (int k = 0; k < n_sent; k++) begin
                b = '0;
                for (int j = 0; j < 8; j++) b = {b[6:0], bitv[d][rises[d] - 1 - (9 * k + j)]};
                chk($sformatf("%s_byte%0d", nm, k), 32'(b), 32'(data[8*k +: 8]));
            end
        end
    endtask

    initial begin
        reset = 1'b1;  start = 1'b0;  numBytes = '0;  dataToSend = '0;  sdaIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_sda%0d", d),  32'(o_sda[d]),  0);
            chk($sformatf("reset_scl%0d", d),  32'(o_scl[d]),  0);
            chk($sformatf("reset_busy%0d", d), 32'(o_busy[d]), 0);
            chk($sformatf("reset_done%0d", d), 32'(o_done[d]), 0);
            chk($sformatf("reset_ack%0d", d),  32'(o_ack[d]),  0);
        end
        @(negedge clk);
        reset = 1'b0;

        // One byte 0xA5, with a start request pulsed while busy.
        run_txn(1, 24'h0000A5, 1'b0, 20);
        check_txn(0, "t1a", 165, 1, 1, 1, 24'h0000A5);
        check_txn(1, "t1b", 165, 1, 1, 1, 24'h0000A5);

        // COM7 reset write, with a start request during the done cycle.
        run_txn(3, 24'h801242, 1'b0, 453);
        check_txn(0, "t2a", 453, 1, 3, 3, 24'h801242);
        check_txn(1, "t2b", 453, 1, 3, 3, 24'h801242);

        // Device NACKs: SCCB master keeps going, strict master stops after byte 0.
        run_txn(3, 24'h801242, 1'b1, 0);
        check_txn(0, "t4_sccb", 453, 0, 3, 3, 24'h801242);
        check_txn(1, "t3_strict", 165, 0, 1, 3, 24'h801242);

        // Zero-length request.
        run_txn(0, 24'hFFFFFF, 1'b0, 0);
        check_txn(0, "t5a", 1, 1, 0, 0, 24'h000000);
        check_txn(1, "t5b", 1, 1, 0, 0, 24'h000000);

        // Reset during bit 4 of byte 1, with start asserted alongside reset.
        @(negedge clk);
        start = 1'b1;  numBytes = 2'd2;  dataToSend = 24'h00C33C;  sdaIn = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (218) @(posedge clk);
        #1;
        chk("mid_busy_a", 32'(o_busy[0]), 1);
        chk("mid_busy_b", 32'(o_busy[1]), 1);
        reset = 1'b1;  start = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_sda%0d", d),  32'(o_sda[d]),  0);
            chk($sformatf("midrst_scl%0d", d),  32'(o_scl[d]),  0);
            chk($sformatf("midrst_busy%0d", d), 32'(o_busy[d]), 0);
            chk($sformatf("midrst_done%0d", d), 32'(o_done[d]), 0);
        end
        reset = 1'b0;  start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_ignored_a", 32'(o_busy[0]), 0);
        chk("rst_start_ignored_b", 32'(o_busy[1]), 0);
        repeat (2) @(posedge clk);

        run_txn(2, 24'h00C33C, 1'b0, 0);
        check_txn(0, "t6a", 309, 1, 2, 2, 24'h00C33C);
        check_txn(1, "t6b", 309, 1, 2, 2, 24'h00C33C);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
Parametrised I2C/SCCB write-transaction engine and successor to the free-running byte shifter used for camera configuration. It derives SCL from the system clock through a divider and generates proper START and STOP conditions. It sends 1..MAX_BYTES bytes MSB-first with a per-byte ACK slot and reports the acknowledge status. It sits between the OV7670 register-init sequencer and the open-drain pad drivers.

Parameters:
CLK_DIV, 4, system clock cycles per quarter SCL period (≥2); SCL period = 4*CLK_DIV cycles
MAX_BYTES, 3, maximum bytes per transaction (address byte included)
IGNORE_NACK, 1, 1 = SCCB mode: a NACK is recorded but the transfer continues; 0 = a NACK aborts to STOP

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high
start  input  1  request; accepted only when busy=0
numBytes  input  $clog2(MAX_BYTES+1)  byte count, sampled on accept
dataToSend  input  8*MAX_BYTES  payload sampled on accept; byte k = bits [8k+7:8k]; byte 0 goes first
sdaIn  input  1  SDA pad readback
sdaDriveLow  output  1  1 = pull SDA low, 0 = release
sclDriveLow  output  1  1 = pull SCL low, 0 = release
busy  output  1  high from the cycle after accept until done
done  output  1  one-cycle pulse at transaction end
deviceAck  output  1  1 = every ACK slot sampled low; valid when done=1, held until the next accept

Behaviour:
- Reset (synchronous): state IDLE; sdaDriveLow=0, sclDriveLow=0, busy=0, done=0, deviceAck=0; divider counter=0. A reset mid-transaction releases both lines on the next edge and sends no STOP.
- Quarter tick: the divider counts 0..CLK_DIV-1 while busy and ticks when it reaches CLK_DIV-1. Every phase lasts exactly one quarter (CLK_DIV cycles). The counter is cleared on accept.
- On accept:
  - latch dataToSend and min(numBytes, MAX_BYTES);
  - clear deviceAck and set it to 1 provisionally;
  - busy=1 on the next cycle.
- numBytes=0: no bus activity; done pulses on the cycle after accept with deviceAck=1; busy stays 0.
- States and line levels (D = sdaDriveLow, C = sclDriveLow):
  - IDLE: D=0, C=0.
  - START_A: D=1, C=0 (SDA falls while SCL is high).
  - START_B: D=1, C=1.
  - BIT, 9 slots per byte (8 data bits MSB-first, then the ACK slot), 4 quarters per slot:
    - q0: C=1, D = ~bit (ACK slot: D=0);
    - q1: C=0;
    - q2: C=0; ACK slot samples sdaIn at the end of q2;
    - q3: C=1.
  - STOP_A: C=1, D=1.
  - STOP_B: C=0, D=1.
  - STOP_C: C=0, D=0 (SDA rises while SCL is high).
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- SDA changes only while SCL is driven low, except in START_A and STOP_C.
- ACK handling:
  - sdaIn=1 at an ACK sample clears deviceAck; it stays 0 until the next accept.
  - IGNORE_NACK=0: after a NACK, go directly to STOP_A and skip the remaining bytes.
  - IGNORE_NACK=1: always send every byte.
- Latency, N bytes, no abort: done asserts exactly (2 + 36N + 3)*CLK_DIV + 1 cycles after the accept edge.
- Simultaneous events:
  - start while busy or during the done cycle: ignored.
  - start with reset: reset wins.
- Input changes after accept have no effect on the transfer in progress.

Test Plan:
1. CLK_DIV=4, numBytes=1, dataToSend[7:0]=0xA5, sdaIn held 0 -> START, then SDA bits 1,0,1,0,0,1,0,1 sampled at SCL rises, then ACK slot and STOP; done pulse 165 cycles after accept; deviceAck=1.
2. numBytes=3, payload 0x42,0x12,0x80 (OV7670 COM7 reset write), sdaIn=0 -> 27 SCL pulses in the order 0x42, 0x12, 0x80; done after (5+108)*4+1=453 cycles; deviceAck=1.
3. IGNORE_NACK=0, numBytes=3, sdaIn=1 in the first ACK slot -> STOP follows directly after byte 0; done at (5+36)*4+1=165; deviceAck=0; bytes 1 and 2 never appear on SDA.
4. IGNORE_NACK=1, same stimulus as 3 -> all 3 bytes sent; done at 453; deviceAck=0.
5. Pulse start while busy, and numBytes=0 when idle -> the busy-time start is ignored; numBytes=0 gives done the next cycle with no line activity.
6. Assert reset during bit 4 of byte 1 -> next edge: sdaDriveLow=0, sclDriveLow=0, busy=0, done=0; a new start then runs a clean full transaction.
